// File: rtl/ping_pong_frame_ram.sv
// Double-buffered frame RAM: multi-port writes into one bank and reads from the
// other. A handshaked flip swaps the banks and can sweep-clear the new write bank.
module ping_pong_frame_ram #(
  parameter int unsigned WRITE_CHANNELS = 2,
  parameter int unsigned READ_CHANNELS  = 2,
  parameter int unsigned ADDR_SIZE      = 8,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned SIZE           = 256,
  parameter bit          CLEAR_ON_FLIP  = 1'b1,
  parameter logic [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [WRITE_CHANNELS-1:0]                 write_enables,
  input  logic [WRITE_CHANNELS-1:0][ADDR_SIZE-1:0]  write_addrs,
  input  logic [WRITE_CHANNELS-1:0][DATA_SIZE-1:0]  data_ins,
  output logic                                      write_ready,
  input  logic [READ_CHANNELS-1:0]                  read_enables,
  input  logic [READ_CHANNELS-1:0][ADDR_SIZE-1:0]   read_addrs,
  output logic [READ_CHANNELS-1:0][DATA_SIZE-1:0]   data_outs,
  output logic [READ_CHANNELS-1:0]                  read_valids,
  input  logic                                      flip_req,
  output logic                                      flip_ready,
  output logic                                      flip_done,
  output logic                                      write_bank
);

  localparam int unsigned        AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AW-1:0]      LAST   = AW'(SIZE - 1);
  localparam logic [ADDR_SIZE:0] SIZE_L = (ADDR_SIZE + 1)'(SIZE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state;
  logic [AW-1:0]          clear_cnt;
  logic [DATA_SIZE-1:0]   ram0 [SIZE];
  logic [DATA_SIZE-1:0]   ram1 [SIZE];

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return {1'b0, a} < SIZE_L;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      write_bank  <= 1'b0;
      clear_cnt   <= '0;
      flip_done   <= 1'b0;
      write_ready <= 1'b1;
      flip_ready  <= 1'b1;
    end else begin
      flip_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flip_req && flip_ready) begin
            write_bank <= ~write_bank;
            if (CLEAR_ON_FLIP) begin
              state       <= CLEAR;
              clear_cnt   <= '0;
              write_ready <= 1'b0;
              flip_ready  <= 1'b0;
            end else begin
              flip_done <= 1'b1;
            end
          end
        end
        CLEAR: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == LAST) begin
            state       <= IDLE;
            clear_cnt   <= '0;
            flip_done   <= 1'b1;
            write_ready <= 1'b1;
            flip_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Later ports overwrite earlier ones in the loop, so the highest index wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        if (write_bank) ram1[clear_cnt] <= CLEAR_VALUE;
        else            ram0[clear_cnt] <= CLEAR_VALUE;
      end else if (write_ready) begin
        for (int unsigned i = 0; i < WRITE_CHANNELS; i++) begin
          if (write_enables[i] && in_range(write_addrs[i])) begin
            if (write_bank) ram1[write_addrs[i][AW-1:0]] <= data_ins[i];
            else            ram0[write_addrs[i][AW-1:0]] <= data_ins[i];
          end
        end
      end
    end
  end

  // The read bank is the one opposite write_bank in the issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_outs   <= '0;
      read_valids <= '0;
    end else begin
      for (int unsigned i = 0; i < READ_CHANNELS; i++) begin
        read_valids[i] <= read_enables[i];
        if (read_enables[i]) begin
          if (!in_range(read_addrs[i])) data_outs[i] <= CLEAR_VALUE;
          else if (write_bank)          data_outs[i] <= ram0[read_addrs[i][AW-1:0]];
          else                          data_outs[i] <= ram1[read_addrs[i][AW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_ping_pong_frame_ram.sv
// Directed bench: one instance without sweep (nc) and one with sweep (cl), SIZE = 16.
module tb_ping_pong_frame_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [1:0]       we_n = '0, re_n = '0, rv_n;
  logic [1:0][7:0]  wa_n = '0, ra_n = '0;
  logic [1:0][15:0] wd_n = '0, do_n;
  logic fr_n = 1'b0, wrdy_n, frdy_n, fd_n, wb_n;

  logic [1:0]       we_c = '0, re_c = '0, rv_c;
  logic [1:0][7:0]  wa_c = '0, ra_c = '0;
  logic [1:0][15:0] wd_c = '0, do_c;
  logic fr_c = 1'b0, wrdy_c, frdy_c, fd_c, wb_c;

  ping_pong_frame_ram #(.WRITE_CHANNELS(2), .READ_CHANNELS(2), .ADDR_SIZE(8), .DATA_SIZE(16),
                        .SIZE(16), .CLEAR_ON_FLIP(1'b0), .CLEAR_VALUE(16'h0000)) dut_nc (
    .clk(clk), .rst(rst), .write_enables(we_n), .write_addrs(wa_n), .data_ins(wd_n),
    .write_ready(wrdy_n), .read_enables(re_n), .read_addrs(ra_n), .data_outs(do_n),
    .read_valids(rv_n), .flip_req(fr_n), .flip_ready(frdy_n), .flip_done(fd_n),
    .write_bank(wb_n));

  ping_pong_frame_ram #(.WRITE_CHANNELS(2), .READ_CHANNELS(2), .ADDR_SIZE(8), .DATA_SIZE(16),
                        .SIZE(16), .CLEAR_ON_FLIP(1'b1), .CLEAR_VALUE(16'h0000)) dut_cl (
    .clk(clk), .rst(rst), .write_enables(we_c), .write_addrs(wa_c), .data_ins(wd_c),
    .write_ready(wrdy_c), .read_enables(re_c), .read_addrs(ra_c), .data_outs(do_c),
    .read_valids(rv_c), .flip_req(fr_c), .flip_ready(frdy_c), .flip_done(fd_c),
    .write_bank(wb_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done_cl(input string tag);
    int n = 0;
    while (fd_c !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, fd_c, 1'b1);
  endtask

  initial begin
    int cnt;
    logic seen;

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_wb_n", wb_n, 1'b0);
    check("rst_wrdy_n", wrdy_n, 1'b1);
    check("rst_frdy_n", frdy_n, 1'b1);
    check("rst_fd_n", fd_n, 1'b0);
    check("rst_rv_n", rv_n, 2'b00);
    check("rst_do_n", do_n, 32'h0);
    check("rst_wb_c", wb_c, 1'b0);
    check("rst_wrdy_c", wrdy_c, 1'b1);
    check("rst_rv_c", rv_c, 2'b00);

    // ---------------- no-clear instance ----------------
    we_n = 2'b01; wa_n[0] = 8'd3; wd_n[0] = 16'hA5A5;
    @(negedge clk);
    we_n = '0; fr_n = 1'b1;
    @(negedge clk);
    fr_n = 1'b0;
    check("flip1_wb", wb_n, 1'b1);
    check("flip1_done", fd_n, 1'b1);
    check("flip1_frdy", frdy_n, 1'b1);
    re_n = 2'b01; ra_n[0] = 8'd3;
    @(negedge clk);
    re_n = '0;
    check("rd3_data", do_n[0], 16'hA5A5);
    check("rd3_valid", rv_n[0], 1'b1);
    check("flip1_done_off", fd_n, 1'b0);
    @(negedge clk);
    check("rd3_valid_drop", rv_n[0], 1'b0);
    check("rd3_hold", do_n[0], 16'hA5A5);

    // Same-address collision: port 1 wins (into bank 1)
    we_n = 2'b11; wa_n[0] = 8'd7; wa_n[1] = 8'd7; wd_n[0] = 16'h1111; wd_n[1] = 16'h2222;
    @(negedge clk);
    we_n = '0; fr_n = 1'b1;
    @(negedge clk);
    fr_n = 1'b0;
    check("flip2_wb", wb_n, 1'b0);
    re_n = 2'b10; ra_n[1] = 8'd7;
    @(negedge clk);
    re_n = '0;
    check("collide_data", do_n[1], 16'h2222);
    check("collide_valid", rv_n[1], 1'b1);

    // Back-to-back flips
    fr_n = 1'b1;
    @(negedge clk);
    check("b2b_wb1", wb_n, 1'b1);
    check("b2b_fd1", fd_n, 1'b1);
    @(negedge clk);
    fr_n = 1'b0;
    check("b2b_wb2", wb_n, 1'b0);
    check("b2b_fd2", fd_n, 1'b1);
    @(negedge clk);
    check("b2b_fd_off", fd_n, 1'b0);

    // Read in the flip-accept cycle uses the old read bank
    we_n = 2'b01; wa_n[0] = 8'd7; wd_n[0] = 16'h3333;
    @(negedge clk);
    we_n = '0; fr_n = 1'b1; re_n = 2'b01; ra_n[0] = 8'd7;
    @(negedge clk);
    fr_n = 1'b0;
    check("flipread_old", do_n[0], 16'h2222);
    check("flipread_wb", wb_n, 1'b1);
    @(negedge clk);
    re_n = '0;
    check("flipread_new", do_n[0], 16'h3333);

    // Out-of-range write must not alias onto addr 0; out-of-range read -> CLEAR_VALUE
    we_n = 2'b11; wa_n[0] = 8'd0; wd_n[0] = 16'h0123; wa_n[1] = 8'd16; wd_n[1] = 16'hBEEF;
    @(negedge clk);
    we_n = '0; fr_n = 1'b1;
    @(negedge clk);
    fr_n = 1'b0;
    re_n = 2'b11; ra_n[0] = 8'd0; ra_n[1] = 8'd16;
    @(negedge clk);
    re_n = '0;
    check("oor_write", do_n[0], 16'h0123);
    check("oor_read", do_n[1], 16'h0000);
    check("oor_valid", rv_n[1], 1'b1);

    // ---------------- clear instance ----------------
    fr_c = 1'b1;
    @(negedge clk);
    fr_c = 1'b0;
    check("cl1_wb", wb_c, 1'b1);
    cnt = 0;
    while (wrdy_c === 1'b0 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("cl1_busy_cycles", cnt, 16);
    check("cl1_done", fd_c, 1'b1);
    check("cl1_frdy", frdy_c, 1'b1);

    for (int a = 0; a < 16; a++) begin
      we_c = '0; we_c[a % 2] = 1'b1;
      wa_c[a % 2] = 8'(a); wd_c[a % 2] = 16'hFFFF;
      @(negedge clk);
    end
    we_c = '0;

    // Flip 2 clears bank 0 while bank 1 (all FFFF) is read; flip_req held throughout
    fr_c = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      check("cl2_wrdy_low", wrdy_c, 1'b0);
      if (i >= 2) check("cl2_read_ffff", {rv_c[1], do_c[1]}, 17'h1FFFF);
      if (i == 16) check("cl2_no_flip", wb_c, 1'b0);
      re_c = 2'b10; ra_c[1] = 8'(i - 1);
      we_c = (i == 10) ? 2'b01 : 2'b00; wa_c[0] = 8'd5; wd_c[0] = 16'h5555;
      @(negedge clk);
    end
    re_c = '0;
    check("cl2_read_last", {rv_c[1], do_c[1]}, 17'h1FFFF);
    check("cl2_done", fd_c, 1'b1);
    check("cl2_wrdy", wrdy_c, 1'b1);
    check("cl2_frdy", frdy_c, 1'b1);
    check("cl2_wb", wb_c, 1'b0);
    @(negedge clk);
    fr_c = 1'b0;
    check("cl3_held_accept", wb_c, 1'b1);
    check("cl3_wrdy_low", wrdy_c, 1'b0);
    re_c = 2'b01; ra_c[0] = 8'd5;
    @(negedge clk);
    re_c = '0;
    check("cl_drop_write", do_c[0], 16'h0000);
    check("cl_drop_valid", rv_c[0], 1'b1);
    wait_done_cl("cl3_done_wait");

    // Flip 4 exposes bank 1, which flip 3 swept
    fr_c = 1'b1;
    @(negedge clk);
    fr_c = 1'b0;
    check("cl4_wb", wb_c, 1'b0);
    wait_done_cl("cl4_done_wait");
    for (int a = 0; a < 16; a++) begin
      re_c = 2'b01; ra_c[0] = 8'(a);
      @(negedge clk);
      check("cl4_swept", {rv_c[0], do_c[0]}, 17'h10000);
    end
    re_c = '0;

    // Reset in the 5th CLEAR cycle
    fr_c = 1'b1;
    @(negedge clk);
    fr_c = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; re_c = 2'b01; ra_c[0] = 8'd1;
    @(negedge clk);
    rst = 1'b0; re_c = '0;
    check("midrst_wb", wb_c, 1'b0);
    check("midrst_wrdy", wrdy_c, 1'b1);
    check("midrst_frdy", frdy_c, 1'b1);
    check("midrst_rv", rv_c, 2'b00);
    check("midrst_do", do_c, 32'h0);
    seen = fd_c;
    repeat (20) begin
      @(negedge clk);
      seen = seen | fd_c;
    end
    check("midrst_no_done", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
